// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_unit_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: imem request/response, redirect, hazard control, IF/ID outputs
interface fetch_unit_if;

   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        set_pc_i;
   logic [31:0] target_pc_i;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        instr_valid_o;

   modport master (
      output imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, set_pc_i, target_pc_i, stall_i, flush_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i, set_pc_i, target_pc_i, stall_i, flush_i
   );

endinterface

// File: rtl/fetch_unit_fifo.sv
// rtl/fetch_unit_fifo.sv - prefetch FIFO of {pc, instr} entries with clear
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int  DEPTH = 2,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           clear,
   input  logic           push,
   input  fetch_entry_t   push_data,
   input  logic           pop,
   output fetch_entry_t   head,
   output logic [CW-1:0]  count,
   output logic           empty,
   output logic           full
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so pointers wrap naturally
   always_ff @(posedge clk_i) begin
      if (rst_i || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: imem request issue, prefetch buffering, redirect discard, IF/ID register
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   fetch_unit_if.master bus
);

   localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [CW-1:0] outstanding_after_rsp;
   logic [CW-1:0] fifo_count;
   logic          req;
   logic          issue;
   logic          push;
   logic          pop;
   logic          fifo_empty;
   logic          fifo_full;
   fetch_entry_t  head;
   fetch_entry_t  push_entry;
   logic [31:0]   instr_q;
   logic [31:0]   pc_q;
   logic          valid_q;

   // Every request reserves a FIFO slot, so a response can never find the FIFO full
   always_comb begin
      req   = !rst_i && !bus.set_pc_i &&
              (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W);
      issue = req && bus.imem_gnt_i;
      outstanding_after_rsp = outstanding - CW'(bus.imem_rvalid_i);
      push  = bus.imem_rvalid_i && !bus.set_pc_i && (discard == '0);
      pop   = !bus.flush_i && !bus.set_pc_i && !bus.stall_i && !fifo_empty;
      push_entry = '{pc: resp_pc, instr: bus.imem_rdata_i};
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear     (bus.set_pc_i),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc    <= BOOT_ADDR;
         resp_pc     <= BOOT_ADDR;
         outstanding <= '0;
         discard     <= '0;
         instr_q     <= NOP_INSTR;
         pc_q        <= '0;
         valid_q     <= 1'b0;
      end else begin
         if (bus.set_pc_i) begin
            // Everything still in flight belongs to the abandoned path
            fetch_pc    <= {bus.target_pc_i[31:2], 2'b00};
            resp_pc     <= {bus.target_pc_i[31:2], 2'b00};
            outstanding <= outstanding_after_rsp;
            discard     <= outstanding_after_rsp;
         end else begin
            if (issue) fetch_pc <= fetch_pc + 32'd4;
            outstanding <= outstanding_after_rsp + CW'(issue);
            if (bus.imem_rvalid_i) begin
               if (discard != '0) discard <= discard - CW'(1);
               else               resp_pc <= resp_pc + 32'd4;
            end
         end

         if (bus.flush_i || bus.set_pc_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
         end else if (bus.stall_i) begin
            valid_q <= valid_q;
         end else if (!fifo_empty) begin
            valid_q <= 1'b1;
            instr_q <= head.instr;
            pc_q    <= head.pc;
         end else begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
         end
      end
   end

   assign bus.imem_req_o    = req;
   assign bus.imem_addr_o   = fetch_pc;
   assign bus.instr_o       = instr_q;
   assign bus.pc_o          = pc_q;
   assign bus.instr_valid_o = valid_q;

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit with memory model and reference scoreboard
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam logic [31:0] BOOT   = 32'h0000_0000;
   localparam int          DEPTH  = 2;
   localparam int          CYCLES = 3000;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } mem_req_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_unit_if bus();

   fetch_unit #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   mem_req_t     pending[$];
   fetch_entry_t arrived[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc    = 0;
   int           epoch  = 0;
   int           loads  = 0;
   bit           armed  = 1'b0;
   logic [31:0]  model_pc;
   logic         exp_valid;
   logic [31:0]  exp_instr;
   logic [31:0]  exp_pc;
   logic         s_req;
   logic [31:0]  s_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: program-order stream of words, epochs mark abandoned requests
   always @(posedge clk) begin
      fetch_entry_t e;
      mem_req_t     h;
      cyc++;
      if (rst) begin
         pending.delete();
         arrived.delete();
         epoch++;
         model_pc  = BOOT;
         exp_valid = 1'b0;
         exp_instr = NOP_INSTR;
         exp_pc    = 32'h0;
         armed     = 1'b1;
      end else if (armed) begin
         if (s_req && bus.imem_gnt_i) begin
            pending.push_back('{addr: s_addr, epoch: epoch, due: cyc + int'($urandom_range(1, 3))});
            model_pc = model_pc + 32'd4;
         end
         if (bus.flush_i || bus.set_pc_i) begin
            exp_valid = 1'b0;
            exp_instr = NOP_INSTR;
            exp_pc    = 32'h0;
         end else if (!bus.stall_i) begin
            if (arrived.size() > 0) begin
               e = arrived.pop_front();
               exp_valid = 1'b1;
               exp_instr = e.instr;
               exp_pc    = e.pc;
               loads++;
            end else begin
               exp_valid = 1'b0;
               exp_instr = NOP_INSTR;
            end
         end
         if (bus.imem_rvalid_i && pending.size() > 0) begin
            h = pending.pop_front();
            if (!bus.set_pc_i && h.epoch == epoch)
               arrived.push_back('{pc: h.addr, instr: mem_word(h.addr)});
         end
         if (bus.set_pc_i) begin
            arrived.delete();
            epoch++;
            model_pc = {bus.target_pc_i[31:2], 2'b00};
         end
      end
   end

   // Monitor: outputs compared mid-cycle against the model
   always @(negedge clk) begin
      logic exp_req;
      s_req  = bus.imem_req_o;
      s_addr = bus.imem_addr_o;
      if (armed) begin
         check32("instr_valid", {31'h0, bus.instr_valid_o}, {31'h0, exp_valid});
         check32("instr", bus.instr_o, exp_instr);
         check32("pc", bus.pc_o, exp_pc);
         exp_req = !rst && !bus.set_pc_i && ((pending.size() + arrived.size()) < DEPTH);
         check32("imem_req", {31'h0, bus.imem_req_o}, {31'h0, exp_req});
         if (exp_req) check32("imem_addr", bus.imem_addr_o, model_pc);
      end
   end

   initial begin
      rst               = 1'b1;
      bus.imem_gnt_i    = 1'b0;
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = 32'h0;
      bus.set_pc_i      = 1'b0;
      bus.target_pc_i   = 32'h0;
      bus.stall_i       = 1'b0;
      bus.flush_i       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int c = 0; c < CYCLES; c++) begin
         rst            = (c == 900 || c == 1900);
         bus.imem_gnt_i = ($urandom_range(0, 3) != 0);
         if (pending.size() > 0 && pending[0].due <= cyc + 1 && $urandom_range(0, 3) != 0) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = mem_word(pending[0].addr);
         end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = $urandom;
         end
         bus.set_pc_i    = ($urandom_range(0, 19) == 0);
         bus.target_pc_i = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                        : 32'($urandom);
         bus.stall_i     = ($urandom_range(0, 6) == 0);
         bus.flush_i     = ($urandom_range(0, 15) == 0);
         @(posedge clk);
         #1;
      end
      checks++;
      if (loads < 100) begin
         errors++;
         $display("FAIL progress loads=%0d required>=100", loads);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
